// File: rtl/vc_pkg.sv
// Shared definitions for the VC read arbiter: FSM state encodings, default
// widths and the destination-select bit helper.
package vc_pkg;

    localparam int DATA_WIDTH_DEF   = 6;
    localparam int UMBRAL_WIDTH_DEF = 4;
    localparam int CNT_WIDTH_DEF    = 5;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    // The word MSB routes it: 0 -> D0, 1 -> D1.
    function automatic int dest_bit_idx(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/vc_read_arbiter_if.sv
// Handshake bundle between the VC FIFO pair, the arbiter and the destination
// FIFO pair. The arbiter uses the slave view, the FIFO environment the master.
interface vc_read_arbiter_if
    import vc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  empty_vc0;
    logic                  empty_vc1;
    logic [DATA_WIDTH-1:0] data_vc0;
    logic [DATA_WIDTH-1:0] data_vc1;
    logic                  error_vc0;
    logic                  error_vc1;
    logic                  rd_vc0;
    logic                  rd_vc1;
    logic                  almost_full_d0;
    logic                  almost_full_d1;
    logic                  push_d0;
    logic                  push_d1;
    logic [DATA_WIDTH-1:0] data_out;

    modport slave (
        input  empty_vc0, empty_vc1, data_vc0, data_vc1, error_vc0, error_vc1,
        input  almost_full_d0, almost_full_d1,
        output rd_vc0, rd_vc1, push_d0, push_d1, data_out
    );

    modport master (
        output empty_vc0, empty_vc1, data_vc0, data_vc1, error_vc0, error_vc1,
        output almost_full_d0, almost_full_d1,
        input  rd_vc0, rd_vc1, push_d0, push_d1, data_out
    );
endinterface

// File: rtl/vc_rr_select.sv
// Pop arbiter for the two VC FIFOs: strict VC0 priority by default, round-robin
// when VC_RR_EN is defined. Outputs are one-hot or zero.
module vc_rr_select (
    input  logic empty_vc0,
    input  logic empty_vc1,
    input  logic stall,
    input  logic last_vc1,
    output logic rd_vc0,
    output logic rd_vc1
);

`ifdef VC_RR_EN
    // With both VCs ready, serve the one not served last.
    always_comb begin
        rd_vc0 = 1'b0;
        rd_vc1 = 1'b0;
        if (!stall) begin
            if (!empty_vc0 && !empty_vc1) begin
                rd_vc0 = last_vc1;
                rd_vc1 = !last_vc1;
            end else if (!empty_vc0) begin
                rd_vc0 = 1'b1;
            end else if (!empty_vc1) begin
                rd_vc1 = 1'b1;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = last_vc1;

    assign rd_vc0 = !stall && !empty_vc0;
    assign rd_vc1 = !stall && empty_vc0 && !empty_vc1;
`endif

endmodule

// File: rtl/vc_read_arbiter.sv
// Drains the VC0/VC1 transmit FIFOs into destination FIFOs D0/D1 and owns the
// VC threshold registers. Define VC_RR_EN for round-robin VC arbitration.
module vc_read_arbiter
    import vc_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int UMBRAL_WIDTH = UMBRAL_WIDTH_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [UMBRAL_WIDTH-1:0] umbral_vc0_in,
    input  logic [UMBRAL_WIDTH-1:0] umbral_vc1_in,
    vc_read_arbiter_if.slave        bus,
    output logic [UMBRAL_WIDTH-1:0] umbral_vc0,
    output logic [UMBRAL_WIDTH-1:0] umbral_vc1,
    output logic [CNT_WIDTH-1:0]    cnt_vc0,
    output logic [CNT_WIDTH-1:0]    cnt_vc1,
    output logic [2:0]              state,
    output logic                    idle,
    output logic                    error
);

    localparam int DBIT = dest_bit_idx(DATA_WIDTH);

    logic [2:0]              state_q, state_d;
    logic [UMBRAL_WIDTH-1:0] umbral_vc0_q, umbral_vc0_d;
    logic [UMBRAL_WIDTH-1:0] umbral_vc1_q, umbral_vc1_d;
    logic [CNT_WIDTH-1:0]    cnt_vc0_q, cnt_vc0_d;
    logic [CNT_WIDTH-1:0]    cnt_vc1_q, cnt_vc1_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    pend_q, pend_d;
    logic                    tag_q, tag_d;
    logic                    last_q, last_d;

    logic                    err_in, stall, pop_ok;
    logic                    sel_rd0, sel_rd1, rd0, rd1;
    logic [DATA_WIDTH-1:0]   pend_word;

    assign err_in = bus.error_vc0 | bus.error_vc1;
    assign stall  = bus.almost_full_d0 | bus.almost_full_d1;
    // No new pops on a cycle that leaves ACTIVE for INIT or ERROR.
    assign pop_ok = (state_q == ST_ACTIVE) && !init && !err_in;

    vc_rr_select u_sel (
        .empty_vc0 (bus.empty_vc0),
        .empty_vc1 (bus.empty_vc1),
        .stall     (stall),
        .last_vc1  (last_q),
        .rd_vc0    (sel_rd0),
        .rd_vc1    (sel_rd1)
    );

    assign rd0 = pop_ok & sel_rd0;
    assign rd1 = pop_ok & sel_rd1;

    // FIFO read data is valid the cycle after the pop; the tag picks the VC.
    assign pend_word = tag_q ? bus.data_vc1 : bus.data_vc0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (init)
                    state_d = ST_INIT;
                else if (!bus.empty_vc0 || !bus.empty_vc1)
                    state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)
                    state_d = ST_INIT;
                else if (bus.empty_vc0 && bus.empty_vc1 && !pend_q)
                    state_d = ST_IDLE;
            end
            default:   state_d = ST_ERROR;
        endcase
        if (state_q != ST_RESET && err_in)
            state_d = ST_ERROR;
    end

    always_comb begin
        umbral_vc0_d = umbral_vc0_q;
        umbral_vc1_d = umbral_vc1_q;
        if (state_q == ST_INIT && init) begin
            umbral_vc0_d = umbral_vc0_in;
            umbral_vc1_d = umbral_vc1_in;
        end
    end

    always_comb begin
        pend_d    = rd0 | rd1;
        tag_d     = rd1 ? 1'b1 : (rd0 ? 1'b0 : tag_q);
        last_d    = rd1 ? 1'b1 : (rd0 ? 1'b0 : last_q);
        hold_d    = pend_q ? pend_word : hold_q;
        cnt_vc0_d = cnt_vc0_q;
        cnt_vc1_d = cnt_vc1_q;
        if (pend_q && !tag_q) cnt_vc0_d = cnt_vc0_q + CNT_WIDTH'(1);
        if (pend_q && tag_q)  cnt_vc1_d = cnt_vc1_q + CNT_WIDTH'(1);
    end

    // last_q resets to VC1 so round-robin starts with VC0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_RESET;
            umbral_vc0_q <= '0;
            umbral_vc1_q <= '0;
            cnt_vc0_q    <= '0;
            cnt_vc1_q    <= '0;
            hold_q       <= '0;
            pend_q       <= 1'b0;
            tag_q        <= 1'b0;
            last_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            umbral_vc0_q <= umbral_vc0_d;
            umbral_vc1_q <= umbral_vc1_d;
            cnt_vc0_q    <= cnt_vc0_d;
            cnt_vc1_q    <= cnt_vc1_d;
            hold_q       <= hold_d;
            pend_q       <= pend_d;
            tag_q        <= tag_d;
            last_q       <= last_d;
        end
    end

    assign bus.rd_vc0   = rd0;
    assign bus.rd_vc1   = rd1;
    assign bus.push_d0  = pend_q & ~pend_word[DBIT];
    assign bus.push_d1  = pend_q & pend_word[DBIT];
    assign bus.data_out = hold_d;

    assign umbral_vc0 = umbral_vc0_q;
    assign umbral_vc1 = umbral_vc1_q;
    assign cnt_vc0    = cnt_vc0_q;
    assign cnt_vc1    = cnt_vc1_q;
    assign state      = state_q;
    assign idle       = (state_q == ST_IDLE);
    assign error      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_vc_read_arbiter.sv
// Bench for vc_read_arbiter: FIFO environment, table vectors, corner sequences
// and a randomized phase scored against a transaction-level model.
module tb_vc_read_arbiter;
    import vc_pkg::*;

    logic       clk, reset, init;
    logic [3:0] umbral_vc0_in, umbral_vc1_in, umbral_vc0, umbral_vc1;
    logic [4:0] cnt_vc0, cnt_vc1;
    logic [2:0] state;
    logic       idle, error;

    vc_read_arbiter_if bif ();

    vc_read_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .umbral_vc0_in (umbral_vc0_in),
        .umbral_vc1_in (umbral_vc1_in),
        .bus           (bif),
        .umbral_vc0    (umbral_vc0),
        .umbral_vc1    (umbral_vc1),
        .cnt_vc0       (cnt_vc0),
        .cnt_vc1       (cnt_vc1),
        .state         (state),
        .idle          (idle),
        .error         (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int              n0;
        int              n1;
        logic [3:0][5:0] w0;
        logic [3:0][5:0] w1;
        int              nexp;
        logic [7:0][5:0] ex;
    } vec_t;

    vec_t       vecs[4];
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic [5:0] got[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    // Model state: words are forwarded in the order the arbitration rule picks.
    bit         chk_on = 0;
    bit         m_active, m_last_vc1, pv, pv_vc1;
    logic [5:0] pw, last_out;
    int         m_cnt0, m_cnt1;

    logic       s_rd0, s_rd1, s_push0, s_push1, s_idle, s_err;
    logic [5:0] s_dout;
    logic [2:0] s_state;
    logic [4:0] s_cnt0, s_cnt1;
    logic [3:0] s_umb0, s_umb1;

    task automatic chk(input string nm, input int got_v, input int exp_v);
        n_tests++;
        if (got_v != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got_v, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_last_vc1 = 1; pv = 0; pv_vc1 = 0;
        pw = '0; last_out = '0; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    task automatic step();
        logic [5:0] pop0, pop1;
        bit e0, e1, x0, x1;
        int order[2];
        pop0 = '0; pop1 = '0; x0 = 0; x1 = 0;
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
        bif.empty_vc0 = e0;
        bif.empty_vc1 = e1;
        @(negedge clk);
        s_rd0 = bif.rd_vc0;   s_rd1 = bif.rd_vc1;
        s_push0 = bif.push_d0; s_push1 = bif.push_d1; s_dout = bif.data_out;
        s_state = state; s_idle = idle; s_err = error;
        s_cnt0 = cnt_vc0; s_cnt1 = cnt_vc1; s_umb0 = umbral_vc0; s_umb1 = umbral_vc1;
        if (s_push0 || s_push1) got.push_back(s_dout);
        if (chk_on) begin
            // Service order list: VC0 first unless round-robin says VC1 is due.
            order[0] = 0; order[1] = 1;
`ifdef VC_RR_EN
            if (!m_last_vc1) begin order[0] = 1; order[1] = 0; end
`endif
            if (m_active && !bif.almost_full_d0 && !bif.almost_full_d1) begin
                for (int i = 0; i < 2; i++) begin
                    if (!x0 && !x1 && order[i] == 0 && !e0) x0 = 1;
                    if (!x0 && !x1 && order[i] == 1 && !e1) x1 = 1;
                end
            end
            chk("rd_vc0", s_rd0, x0);
            chk("rd_vc1", s_rd1, x1);
            chk("push_d0", s_push0, pv && !pw[5]);
            chk("push_d1", s_push1, pv && pw[5]);
            chk("data_out", s_dout, pv ? pw : last_out);
            chk("cnt_vc0", s_cnt0, m_cnt0 % 32);
            chk("cnt_vc1", s_cnt1, m_cnt1 % 32);
            chk("state", s_state, m_active ? 3 : 2);
            chk("idle", s_idle, !m_active);
            if (pv) begin
                last_out = pw;
                if (pv_vc1) m_cnt1++; else m_cnt0++;
            end
            if (!m_active) m_active = !e0 || !e1;
            else if (e0 && e1 && !pv) m_active = 0;
        end
        if (s_rd0 && q0.size() > 0) pop0 = q0.pop_front();
        if (s_rd1 && q1.size() > 0) pop1 = q1.pop_front();
        pv = s_rd0 || s_rd1;
        pv_vc1 = s_rd1;
        pw = s_rd1 ? pop1 : pop0;
        if (s_rd0) m_last_vc1 = 0;
        if (s_rd1) m_last_vc1 = 1;
        @(posedge clk);
        #1;
        if (s_rd0) bif.data_vc0 = pop0;
        if (s_rd1) bif.data_vc1 = pop1;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (!m_active && q0.size() == 0 && q1.size() == 0 && !pv) begin
                done = 1;
                break;
            end
        end
        chk("drain_done", done, 1);
    endtask

    initial begin
        reset = 0; init = 0; umbral_vc0_in = 0; umbral_vc1_in = 0;
        bif.empty_vc0 = 1; bif.empty_vc1 = 1; bif.data_vc0 = 0; bif.data_vc1 = 0;
        bif.error_vc0 = 0; bif.error_vc1 = 0; bif.almost_full_d0 = 0; bif.almost_full_d1 = 0;

        vecs[0] = '{2, 2, {6'h00, 6'h00, 6'h02, 6'h01}, {6'h00, 6'h00, 6'h22, 6'h21}, 4,
`ifdef VC_RR_EN
                    {6'h00, 6'h00, 6'h00, 6'h00, 6'h22, 6'h02, 6'h21, 6'h01}};
`else
                    {6'h00, 6'h00, 6'h00, 6'h00, 6'h22, 6'h21, 6'h02, 6'h01}};
`endif
        vecs[1] = '{2, 0, {6'h00, 6'h00, 6'h25, 6'h05}, {6'h00, 6'h00, 6'h00, 6'h00}, 2,
                    {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h25, 6'h05}};
        vecs[2] = '{0, 2, {6'h00, 6'h00, 6'h00, 6'h00}, {6'h00, 6'h00, 6'h0A, 6'h30}, 2,
                    {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0A, 6'h30}};
        vecs[3] = '{1, 1, {6'h00, 6'h00, 6'h00, 6'h3F}, {6'h00, 6'h00, 6'h00, 6'h00}, 2,
                    {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F}};

        // Reset, then program thresholds.
        step(); step();
        chk("rst_state", s_state, 0);
        chk("rst_rd", {s_rd0, s_rd1}, 0);
        chk("rst_push", {s_push0, s_push1}, 0);
        chk("rst_data_out", s_dout, 0);
        chk("rst_cnt", {s_cnt0, s_cnt1}, 0);
        chk("rst_umbral", {s_umb0, s_umb1}, 0);
        chk("rst_flags", {s_idle, s_err}, 0);
        reset = 1; init = 1; umbral_vc0_in = 3; umbral_vc1_in = 5;
        step();
        step();
        chk("init_state", s_state, 1);
        init = 0; umbral_vc0_in = 9; umbral_vc1_in = 9;
        step();
        chk("umbral_vc0", s_umb0, 3);
        chk("umbral_vc1", s_umb1, 5);
        model_reset();
        chk_on = 1;
        step();
        chk("idle_state", s_state, 2);
        chk("idle_flag", s_idle, 1);
        chk("umbral_hold", {s_umb0, s_umb1}, {4'd3, 4'd5});

        // Table vectors: load both FIFOs, drain, compare forwarded order.
        for (int v = 0; v < 4; v++) begin
            got.delete();
            for (int i = 0; i < vecs[v].n0; i++) q0.push_back(vecs[v].w0[i]);
            for (int i = 0; i < vecs[v].n1; i++) q1.push_back(vecs[v].w1[i]);
            drain();
            chk($sformatf("vec%0d_count", v), got.size(), vecs[v].nexp);
            for (int i = 0; i < vecs[v].nexp; i++)
                chk($sformatf("vec%0d_word%0d", v, i),
                    (i < got.size()) ? int'(got[i]) : -1, int'(vecs[v].ex[i]));
        end

        // Back-pressure on D1 holds off VC1 pops.
        q1.push_back(6'h2A);
        bif.almost_full_d1 = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_rd_vc1", s_rd1, 0);
        end
        bif.almost_full_d1 = 0;
        step();
        chk("resume_rd_vc1", s_rd1, 1);
        step();
        chk("resume_push_d1", s_push1, 1);
        chk("resume_data", s_dout, 6'h2A);
        drain();

        // A word popped just before back-pressure rises is still pushed.
        q0.push_back(6'h11); q0.push_back(6'h12);
        step();
        step();
        chk("pre_af_pop", s_rd0, 1);
        bif.almost_full_d0 = 1;
        step();
        chk("af_push_d0", s_push0, 1);
        chk("af_data", s_dout, 6'h11);
        chk("af_no_pop", s_rd0, 0);
        bif.almost_full_d0 = 0;
        drain();

        // Randomized traffic and back-pressure.
        for (int c = 0; c < 300; c++) begin
            if (q0.size() < 6 && $urandom_range(0, 2) == 0) q0.push_back(6'($urandom_range(0, 63)));
            if (q1.size() < 6 && $urandom_range(0, 2) == 0) q1.push_back(6'($urandom_range(0, 63)));
            bif.almost_full_d0 = ($urandom_range(0, 3) == 0);
            bif.almost_full_d1 = ($urandom_range(0, 3) == 0);
            step();
        end
        bif.almost_full_d0 = 0; bif.almost_full_d1 = 0;
        drain();

        // Error is sticky until reset.
        chk_on = 0;
        for (int i = 0; i < 4; i++) q0.push_back(6'(i + 1));
        step();
        step();
        chk("err_pre_pop", s_rd0, 1);
        bif.error_vc1 = 1;
        step();
        bif.error_vc1 = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("err_state", s_state, 4);
            chk("err_flag", s_err, 1);
            chk("err_no_pop", {s_rd0, s_rd1}, 0);
            chk("err_no_push", {s_push0, s_push1}, 0);
        end
        q0.delete();
        reset = 0;
        step();
        step();
        chk("err_rst_state", s_state, 0);
        chk("err_rst_flag", s_err, 0);
        reset = 1; init = 1;
        step();
        init = 0;
        step();
        model_reset();
        chk_on = 1;

        // Counter wrap: 33 VC0 words leave cnt_vc0 at 1.
        for (int i = 0; i < 33; i++) q0.push_back(6'($urandom_range(0, 63)));
        drain();
        step(); step();
        chk("cnt_wrap", s_cnt0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_read_arbiter.md
Name: vc_read_arbiter

Overview:
- Consumer end of the VC0/VC1 transmit FIFOs: pops words from both virtual-channel FIFOs and forwards each word to one of two downstream destination FIFOs (D0/D1).
- Respects downstream almost-full back-pressure.
- Owns the threshold (umbral) registers programmed during init and driven to the VC FIFOs.
- Sits between the VC FIFO pair and the destination FIFO pair in the transmit layer.

Parameters:
- DATA_WIDTH, 6, word width; MSB selects destination (0 -> D0, 1 -> D1).
- UMBRAL_WIDTH, 4, width of threshold registers.
- CNT_WIDTH, 5, width of per-VC forwarded-word counters (wrap-around).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- init  in  1  high = program thresholds; forwarding halted.
- umbral_vc0_in  in  UMBRAL_WIDTH  threshold value to latch for VC0.
- umbral_vc1_in  in  UMBRAL_WIDTH  threshold value to latch for VC1.
- empty_vc0, empty_vc1  in  1  VC FIFO empty flags.
- data_vc0, data_vc1  in  DATA_WIDTH  registered VC FIFO read data; valid the cycle after the pop.
- error_vc0, error_vc1  in  1  VC FIFO overflow error.
- almost_full_d0, almost_full_d1  in  1  destination back-pressure.
- rd_vc0, rd_vc1  out  1  pop strobes to the VC FIFOs.
- push_d0, push_d1  out  1  write strobes to the destinations.
- data_out  out  DATA_WIDTH  word to the destinations.
- umbral_vc0, umbral_vc1  out  UMBRAL_WIDTH  latched thresholds.
- cnt_vc0, cnt_vc1  out  CNT_WIDTH  words forwarded per VC.
- state  out  3  FSM state encoding.
- idle  out  1  high in IDLE.
- error  out  1  sticky error flag.

Behaviour:
- Reset (reset==0 at posedge clk):
  - All outputs go to 0 and state=RESET.
  - The registered-pop tag and the pending-pop flag clear.
- FSM states: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- Transitions:
  - RESET -> INIT once reset==1.
  - INIT: latches umbral_vcX_in into umbral_vcX on every cycle with init==1. When init==0, go to IDLE; thresholds hold.
  - IDLE -> ACTIVE when (~empty_vc0 | ~empty_vc1).
  - ACTIVE -> IDLE when both are empty and no pop is pending.
  - IDLE/ACTIVE -> INIT when init==1. The in-flight pending word is still pushed on the next cycle; no new pops are issued.
  - Any state except RESET -> ERROR when error_vc0|error_vc1. ERROR is sticky until reset, with error=1 and no pops or pushes.
- Pop rule (ACTIVE only; also allowed on the IDLE->ACTIVE transition cycle is NOT permitted, so the first pop occurs in ACTIVE):
  - Stall: no pop while almost_full_d0|almost_full_d1.
  - Otherwise pop VC0 if ~empty_vc0, else VC1 if ~empty_vc1 (strict priority).
  - At most one rd_vcX high per cycle.
  - Back-to-back pops are allowed.
- Latency: pop at cycle N; at N+1, data_out=data_vcX (selected by a registered VC tag) and push_dM=1 with M=data_vcX[DATA_WIDTH-1]. At most one push per cycle.
- When no push occurs, data_out holds its last value and push_d0=push_d1=0.
- A pending word is always pushed, even if almost_full is asserted at N+1. The destination's almost-full margin absorbs it.
- cnt_vcX increments on each push sourced from VC X and wraps from 2^CNT_WIDTH-1 to 0.
- Reset mid-operation discards the pending word. No push occurs.

Optional Feature:
- VC_RR_EN defined: round-robin arbitration. When both VCs are non-empty, alternate pops starting with VC0 after reset. A single non-empty VC is served every cycle. The last-served pointer is held during stalls.
- VC_RR_EN undefined: strict VC0 priority as above.

Decomposition:
- Shared package (vc_pkg) holds:
  - State encodings RESET/INIT/IDLE/ACTIVE/ERROR as 3-bit localparams.
  - Default widths DATA_WIDTH/UMBRAL_WIDTH/CNT_WIDTH.
  - The destination-select bit index.
- One natural sub-module: vc_rr_select, the pop arbiter. Inputs: the empties, stall and last-served pointer. Outputs: one-hot rd_vc0/rd_vc1. It contains both the priority and VC_RR_EN variants.

Test Plan:
- Reset low 2 cycles, then high with init=1 and umbral_vc0_in=3 and umbral_vc1_in=5, then init=0 -> umbral_vc0=3, umbral_vc1=5, state passes RESET->INIT->IDLE, idle=1, all strobes 0.
- VC0 holds 0x05 and 0x25, VC1 empty -> rd_vc0 high 2 consecutive cycles, push_d0 with data_out=0x05, then push_d1 with data_out=0x25 one cycle later; cnt_vc0=2; returns to IDLE.
- Both VCs non-empty with 2 words each (no VC_RR_EN) -> both VC0 words are forwarded before any VC1 word. With VC_RR_EN the order is VC0, VC1, VC0, VC1.
- almost_full_d1=1 while VC1 is non-empty -> rd_vc1 stays 0. After it deasserts, a pop resumes the next cycle. A word popped the cycle before assertion is still pushed.
- Pulse error_vc1 during ACTIVE -> state=ERROR, error=1, no further pops. After a reset pulse: state=RESET, error=0.
- Forward 33 words from VC0 -> cnt_vc0 wraps to 1.
